gpio_debounce: RTL

Input-conditioning stage between the board button pads (UP/DOWN/LEFT/RIGHT/A/B) and the `gpio_in` port of the slurm16 core. It does three things per pin:
- synchronises each asynchronous pin into the `CLK` domain;
- debounces it against a shared 1 kHz tick;
- latches sticky press events and raises a registered interrupt the CPU can mask and clear.

It replaces the direct pad-to-`gpio_in` connection in the iCE40 top level.

---
 rtl/gpio_debounce_pkg.sv | 31 +++
 rtl/gpio_debounce_if.sv | 45 ++++
 rtl/gpio_debounce_channel.sv | 74 +++++++
 rtl/gpio_debounce.sv | 113 +++++++++++
 4 files changed

// File: rtl/gpio_debounce_pkg.sv
// slurm16 I/O package: default debounce configuration, prescaler helper and
// the button index map shared by the top level and the firmware headers.
package slurm16_io_pkg;

  localparam int DEFAULT_CLOCK_FREQ  = 25125000;
  localparam int DEFAULT_NUM_INPUTS  = 6;
  localparam int DEFAULT_DEBOUNCE_MS = 10;

  // Button positions within PINS_IN / STATE_OUT / event vectors.
  typedef enum logic [2:0] {
    BTN_UP    = 3'd0,
    BTN_DOWN  = 3'd1,
    BTN_LEFT  = 3'd2,
    BTN_RIGHT = 3'd3,
    BTN_A     = 3'd4,
    BTN_B     = 3'd5
  } btn_idx_e;

  localparam int BTN_IDX_UP    = 0;
  localparam int BTN_IDX_DOWN  = 1;
  localparam int BTN_IDX_LEFT  = 2;
  localparam int BTN_IDX_RIGHT = 3;
  localparam int BTN_IDX_A     = 4;
  localparam int BTN_IDX_B     = 5;

  // Clock cycles per 1 kHz debounce tick.
  function automatic int tick_div(input int clock_freq);
    return clock_freq / 1000;
  endfunction

endpackage

// File: rtl/gpio_debounce_if.sv
// Button-conditioning bus between the pad side / CPU side (master) and the
// gpio_debounce block (slave).
//
// Signalling: there is no valid/ready handshake on this bus. PINS_IN is an
// asynchronous level. IRQ_MASK is a level. CLR_PRESS / CLR_RELEASE are
// single-cycle strobes sampled on the rising clock edge; a strobe asserted in
// cycle n clears the flag at the edge ending cycle n, unless the same edge
// also sets it. STATE_OUT, PRESS_EVT, RELEASE_EVT and IRQ are registered
// levels.
interface gpio_debounce_if #(
  parameter int NUM_INPUTS = slurm16_io_pkg::DEFAULT_NUM_INPUTS
);

  logic [NUM_INPUTS-1:0] PINS_IN;
  logic [NUM_INPUTS-1:0] IRQ_MASK;
  logic [NUM_INPUTS-1:0] CLR_PRESS;
  logic [NUM_INPUTS-1:0] CLR_RELEASE;
  logic [NUM_INPUTS-1:0] STATE_OUT;
  logic [NUM_INPUTS-1:0] PRESS_EVT;
  logic [NUM_INPUTS-1:0] RELEASE_EVT;
  logic                  IRQ;

  modport master (
    output PINS_IN,
    output IRQ_MASK,
    output CLR_PRESS,
    output CLR_RELEASE,
    input  STATE_OUT,
    input  PRESS_EVT,
    input  RELEASE_EVT,
    input  IRQ
  );

  modport slave (
    input  PINS_IN,
    input  IRQ_MASK,
    input  CLR_PRESS,
    input  CLR_RELEASE,
    output STATE_OUT,
    output PRESS_EVT,
    output RELEASE_EVT,
    output IRQ
  );

endinterface

// File: rtl/gpio_debounce_channel.sv
// One debounce channel: two-flop synchroniser, polarity normalisation,
// tick-driven stability counter, debounced state flop and rise/fall pulses.
// The pulses are combinational and coincide with the edge that updates the
// state flop, so the parent's event flags change in the same cycle.
module debounce_channel #(
  parameter int DEBOUNCE_MS = slurm16_io_pkg::DEFAULT_DEBOUNCE_MS,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic pin_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int   CNT_W    = $clog2(DEBOUNCE_MS + 1);
  localparam logic RELEASED = (ACTIVE_LOW != 0);

  logic [1:0]       sync_q;
  logic             r;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit;

  // Synchroniser resets to the released pad level so reset reads "not pressed".
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RELEASED}};
    end else begin
      sync_q <= {sync_q[0], pin_i};
    end
  end

  // Normalised level: 1 = pressed, independent of pad polarity.
  assign r = sync_q[1] ^ RELEASED;

  // Counter clears whenever the input agrees with the state, so any bounce
  // back discards progress; the threshold check happens before the increment
  // so the counter never reaches DEBOUNCE_MS.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    commit  = 1'b0;
    if (r == state_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_W'(DEBOUNCE_MS - 1)) begin
        commit  = 1'b1;
        state_d = r;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and debounced state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = commit & r;
  assign fall_o  = commit & ~r;

endmodule

// File: rtl/gpio_debounce.sv
// gpio_debounce: conditions the board buttons for the slurm16 gpio_in port.
// Owns the 1 kHz prescaler, the sticky press/release flags and the registered
// interrupt; per-pin synchronise/debounce lives in debounce_channel.
//
// Build option: define GPIO_DEBOUNCE_RELEASE_EVT_EN to latch release events
// and let them drive IRQ. Without it RELEASE_EVT reads 0, CLR_RELEASE is
// ignored and no release-flag flops exist.
module gpio_debounce
  import slurm16_io_pkg::*;
#(
  parameter int CLOCK_FREQ  = DEFAULT_CLOCK_FREQ,
  parameter int NUM_INPUTS  = DEFAULT_NUM_INPUTS,
  parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic            CLK,
  input  logic            RSTb,
  gpio_debounce_if.slave  bus
);

  localparam int TICK_DIV = tick_div(CLOCK_FREQ);
  localparam int PRE_W    = $clog2(TICK_DIV);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic                  tick;
  logic [NUM_INPUTS-1:0] state;
  logic [NUM_INPUTS-1:0] rise;
  logic [NUM_INPUTS-1:0] fall;
  logic [NUM_INPUTS-1:0] press_q, press_d;
  logic [NUM_INPUTS-1:0] evt;
  logic                  irq_q, irq_d;

  // Prescaler: counts 0..TICK_DIV-1, tick marks the terminal count.
  assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

  // Prescaler register.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk_i   (CLK),
      .rst_ni  (RSTb),
      .tick_i  (tick),
      .pin_i   (bus.PINS_IN[g]),
      .state_o (state[g]),
      .rise_o  (rise[g]),
      .fall_o  (fall[g])
    );
  end

  // Set has priority over a coincident clear strobe.
  assign press_d = (press_q & ~bus.CLR_PRESS) | rise;

  // Sticky press flags.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      press_q <= '0;
    end else begin
      press_q <= press_d;
    end
  end

`ifdef GPIO_DEBOUNCE_RELEASE_EVT_EN
  logic [NUM_INPUTS-1:0] rel_q, rel_d;

  assign rel_d = (rel_q & ~bus.CLR_RELEASE) | fall;

  // Sticky release flags.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      rel_q <= '0;
    end else begin
      rel_q <= rel_d;
    end
  end

  assign evt             = press_q | rel_q;
  assign bus.RELEASE_EVT = rel_q;
`else
  // Release path compiled out; keep the dangling inputs visibly intentional.
  logic unused_release;
  assign unused_release  = ^{fall, bus.CLR_RELEASE};
  assign evt             = press_q;
  assign bus.RELEASE_EVT = '0;
`endif

  // Level interrupt from the masked flags, registered one cycle behind them.
  assign irq_d = |(evt & bus.IRQ_MASK);

  // Interrupt register.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.STATE_OUT = state;
  assign bus.PRESS_EVT = press_q;
  assign bus.IRQ       = irq_q;

endmodule
